// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// divider_pkg - shared types and constants for seq_restoring_divider (rev 1.0)
// ----------------------------------------------------------------------------
package divider_pkg;

  localparam int DEF_N_W = 16;
  localparam int DEF_D_W = 8;

  // Wide all-ones source; truncated to the quotient width at the use site.
  localparam logic [63:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_restoring_divider_if - operand/result handshake bundle (rev 1.0)
// ----------------------------------------------------------------------------
interface seq_restoring_divider_if
  import divider_pkg::*;
#(
  parameter int N_W = DEF_N_W,
  parameter int D_W = DEF_D_W
);
  logic           in_valid;
  logic           in_ready;
  logic [N_W-1:0] dividend;
  logic [D_W-1:0] divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N_W-1:0] quotient;
  logic [D_W-1:0] remainder;
  logic           div_by_zero;
  logic           busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );
endinterface
`default_nettype wire

// File: rtl/seq_restoring_divider_div_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// div_step - one restoring-division iteration, combinational (rev 1.0)
// ----------------------------------------------------------------------------
module div_step #(
  parameter int D_W = 8
) (
  input  logic [D_W-1:0] pr,
  input  logic           in_bit,
  input  logic [D_W-1:0] divisor,
  output logic [D_W-1:0] pr_next,
  output logic           q_bit
);
  logic [D_W:0] shifted;
  logic [D_W:0] diff;

  assign shifted = {pr, in_bit};
  assign diff    = shifted - {1'b0, divisor};
  // With pr < divisor the difference's top bit is exactly the borrow.
  assign q_bit   = ~diff[D_W];
  assign pr_next = q_bit ? diff[D_W-1:0] : shifted[D_W-1:0];
endmodule
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_restoring_divider - unsigned N_W/D_W restoring divider, 1 bit/clk (rev 1.0)
// ----------------------------------------------------------------------------
module seq_restoring_divider
  import divider_pkg::*;
#(
  parameter int N_W = DEF_N_W,
  parameter int D_W = DEF_D_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int             CNT_W = cnt_width(N_W);
  localparam logic [N_W-1:0] DBZ_Q = N_W'(DBZ_QUOTIENT);

  state_t           state, state_nx;
  logic [N_W-1:0]   q_reg;
  logic [D_W-1:0]   pr_reg;
  logic [D_W-1:0]   dsr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             dbz_reg;
  logic [D_W-1:0]   pr_step;
  logic             q_bit;

  div_step #(.D_W(D_W)) u_step (
    .pr      (pr_reg),
    .in_bit  (q_reg[N_W-1]),
    .divisor (dsr_reg),
    .pr_next (pr_step),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = (bus.divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (cnt_reg == '0) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Quotient and remainder registers double as the result outputs; they are
  // only disturbed on acceptance and in RUN, so they hold through DONE/IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg   <= '0;
      pr_reg  <= '0;
      dsr_reg <= '0;
      cnt_reg <= '0;
      dbz_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dsr_reg <= bus.divisor;
            cnt_reg <= CNT_W'(N_W - 1);
            if (bus.divisor == '0) begin
              q_reg   <= DBZ_Q;
              pr_reg  <= bus.dividend[D_W-1:0];
              dbz_reg <= 1'b1;
            end else begin
              q_reg   <= bus.dividend;
              pr_reg  <= '0;
              dbz_reg <= 1'b0;
            end
          end
        end
        RUN: begin
          pr_reg  <= pr_step;
          q_reg   <= {q_reg[N_W-2:0], q_bit};
          cnt_reg <= cnt_reg - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = q_reg;
  assign bus.remainder   = pr_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seq_restoring_divider - directed/table bench for seq_restoring_divider (rev 1.0)
// ----------------------------------------------------------------------------
module tb_seq_restoring_divider;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  seq_restoring_divider_if bus ();

  seq_restoring_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] q, output logic [7:0] r,
                         output logic dbz, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    q   = bus.quotient;
    r   = bus.remainder;
    dbz = bus.div_by_zero;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          lat;

    n_vec  = 0;
    n_miss = 0;
    vecs[0]  = '{16'd100,   8'd0,   16'hFFFF, 8'h64, 1'b1};
    vecs[1]  = '{16'd65025, 8'd255, 16'd255,  8'd0,  1'b0};
    vecs[2]  = '{16'd65535, 8'd7,   16'd9362, 8'd1,  1'b0};
    vecs[3]  = '{16'd5,     8'd200, 16'd0,    8'd5,  1'b0};
    vecs[4]  = '{16'd40000, 8'd9,   16'd4444, 8'd4,  1'b0};
    vecs[5]  = '{16'd1000,  8'd3,   16'd333,  8'd1,  1'b0};
    vecs[6]  = '{16'd12345, 8'd1,   16'd12345,8'd0,  1'b0};
    vecs[7]  = '{16'd0,     8'd5,   16'd0,    8'd0,  1'b0};
    vecs[8]  = '{16'd65535, 8'd0,   16'hFFFF, 8'hFF, 1'b1};
    vecs[9]  = '{16'd255,   8'd255, 16'd1,    8'd0,  1'b0};
    vecs[10] = '{16'd65535, 8'd255, 16'd257,  8'd0,  1'b0};
    vecs[11] = '{16'd300,   8'd0,   16'hFFFF, 8'h2C, 1'b1};
    vecs[12] = '{16'd65535, 8'd1,   16'd65535,8'd0,  1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    #12;
    check("rst in_ready",  32'(bus.in_ready), 32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst busy",      32'(bus.busy), 32'd0);
    check("rst quotient",  32'(bus.quotient), 32'd0);
    check("rst remainder", 32'(bus.remainder), 32'd0);
    check("rst dbz",       32'(bus.div_by_zero), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      run_div(vecs[i].a, vecs[i].b, q, r, dbz, lat);
      check($sformatf("vec%0d quotient", i),  32'(q),   32'(vecs[i].q));
      check($sformatf("vec%0d remainder", i), 32'(r),   32'(vecs[i].r));
      check($sformatf("vec%0d dbz", i),       32'(dbz), 32'(vecs[i].dbz));
      check($sformatf("vec%0d latency", i),   32'(lat), (vecs[i].b == 8'd0) ? 32'd1 : 32'd17);
      check($sformatf("vec%0d in_ready after", i), 32'(bus.in_ready), 32'd1);
      check($sformatf("vec%0d out_valid after", i), 32'(bus.out_valid), 32'd0);
    end

    // Back-pressure: 1000/3 held in DONE, stray in_valid pulses ignored.
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp busy", 32'(bus.busy), 32'd1);
    check("bp in_ready run", 32'(bus.in_ready), 32'd0);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      if (lat == 4) begin
        bus.dividend = 16'd7;
        bus.divisor  = 8'd2;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    check("bp latency", 32'(lat), 32'd17);
    bus.dividend = 16'd7;
    bus.divisor  = 8'd0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("bp quotient hold",  32'(bus.quotient), 32'd333);
      check("bp remainder hold", 32'(bus.remainder), 32'd1);
      check("bp out_valid hold", 32'(bus.out_valid), 32'd1);
      check("bp in_ready done",  32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("bp in_ready after", 32'(bus.in_ready), 32'd1);
    check("bp out_valid after", 32'(bus.out_valid), 32'd0);
    check("bp quotient kept", 32'(bus.quotient), 32'd333);
    @(posedge clk); #1;
    check("bp stays idle", 32'(bus.in_ready), 32'd1);

    // Asynchronous reset after iteration 8 of 40000/9.
    bus.dividend = 16'd40000;
    bus.divisor  = 8'd9;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("mid busy before rst", 32'(bus.busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid rst in_ready",  32'(bus.in_ready), 32'd1);
    check("mid rst busy",      32'(bus.busy), 32'd0);
    check("mid rst out_valid", 32'(bus.out_valid), 32'd0);
    check("mid rst quotient",  32'(bus.quotient), 32'd0);
    check("mid rst remainder", 32'(bus.remainder), 32'd0);
    check("mid rst dbz",       32'(bus.div_by_zero), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post rst out_valid", 32'(bus.out_valid), 32'd0);
    run_div(16'd40000, 8'd9, q, r, dbz, lat);
    check("post rst quotient",  32'(q), 32'd4444);
    check("post rst remainder", 32'(r), 32'd4);
    check("post rst latency",   32'(lat), 32'd17);

    // Random operands against the bench's own arithmetic.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      run_div(a, b, q, r, dbz, lat);
      check($sformatf("rand %0d/%0d", a, b), {8'd0, q, r}, {8'd0, a / 16'(b), 8'(a % 16'(b))});
    end

    // Products of 8x8 operands divided back by the nonzero multiplier operand.
    for (int x = 1; x < 256; x += 14) begin
      for (int y = 0; y < 256; y += 11) begin
        logic [15:0] p;
        p = 16'(x * y);
        run_div(p, 8'(x), q, r, dbz, lat);
        check($sformatf("prod %0d/%0d", p, x), {8'd0, q, r}, {8'd0, 16'(y), 8'd0});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire
